// File: rtl/weapons_pkg.sv
// Shared weapon-control encodings: sequencer states, ship mode and fire-mode codes.
// Pure definitions, no logic.
package weapons_pkg;
   localparam int         N_DEFAULT   = 9;
   localparam logic [3:0] MODE_ATTACK = 4'b0010;
   localparam logic [1:0] FM_SINGLE   = 2'b00;
   localparam logic [1:0] FM_BURST    = 2'b01;
   localparam logic [1:0] FM_AUTO     = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FIRE,
      ST_COOL,
      ST_RELOAD
   } state_t;
endpackage

// File: rtl/fire_control_sequencer_shot_timer.sv
// shot_timer: loadable down-counter; done is high during the last counted cycle.
// Load takes effect on the next edge, so a load of K gives K cycles ending with done.
module shot_timer #(
   parameter int N = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] load_val,
   output logic         done
);
   logic [N-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == N'(1));
endmodule

// File: rtl/fire_control_sequencer.sv
// Trigger-to-shot sequencer feeding the ammo counter: fire strobes, latched rate, reload pulses.
// Registered (Moore) outputs; a qualifying trigger sampled at edge n fires in the following cycle.
module fire_control_sequencer
   import weapons_pkg::*;
#(
   parameter int N           = N_DEFAULT,
   parameter int COOL_CYCLES = 4,
   parameter int BURST_LEN   = 3,
   parameter int LOAD_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         trigger,
   input  logic [3:0]   mode_sel,
   input  logic [1:0]   fire_mode,
   input  logic [N-1:0] shot_size,
   input  logic [N-1:0] ammo_level,
   input  logic         reload_req,
   input  logic [N-1:0] reload_amt,
   output logic         fire,
   output logic [N-1:0] fire_rate,
   output logic         load,
   output logic [N-1:0] ammo_out,
   output logic         busy,
   output logic         error
);
   state_t       state, state_nxt;
   logic         trig_q, armed;
   logic [N-1:0] burst_cnt;
   logic         trig_edge, ok, req, is_burst, is_auto;
   logic         fire_start, reload_start, burst_dec, err_set;
   logic         cool_done, load_done;

   // armed blocks an edge from a trigger that was already held when reset released
   assign trig_edge = trigger & ~trig_q & armed;
   assign ok        = (mode_sel == MODE_ATTACK) && (shot_size != '0) && (ammo_level >= shot_size);
   assign is_burst  = (fire_mode == FM_BURST);
   assign is_auto   = (fire_mode == FM_AUTO);
   assign req       = is_auto ? trigger : trig_edge;

   shot_timer #(.N(N)) u_cool_tmr (
      .clk      (clk),
      .rst      (rst),
      .load     (state == ST_FIRE),
      .load_val (N'(COOL_CYCLES)),
      .done     (cool_done)
   );

   shot_timer #(.N(N)) u_load_tmr (
      .clk      (clk),
      .rst      (rst),
      .load     (reload_start),
      .load_val (N'(LOAD_CYCLES)),
      .done     (load_done)
   );

   always_comb begin
      state_nxt    = state;
      fire_start   = 1'b0;
      reload_start = 1'b0;
      burst_dec    = 1'b0;
      err_set      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (reload_req) begin
               state_nxt    = ST_RELOAD;
               reload_start = 1'b1;
            end else if (req && ok) begin
               state_nxt  = ST_FIRE;
               fire_start = 1'b1;
            end else if (req) begin
               err_set = 1'b1;
            end
         end
         ST_FIRE: state_nxt = ST_COOL;
         ST_COOL: begin
            if (cool_done) begin
               if (is_burst && (burst_cnt != '0) && ok) begin
                  state_nxt = ST_FIRE;
                  burst_dec = 1'b1;
               end else if (is_auto && trigger && ok) begin
                  state_nxt = ST_FIRE;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_RELOAD: if (load_done) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Rate is captured only when a sequence starts, never between burst/auto shots
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fire      <= 1'b0;
         load      <= 1'b0;
         busy      <= 1'b0;
         error     <= 1'b0;
         fire_rate <= '0;
         ammo_out  <= '0;
         burst_cnt <= '0;
         trig_q    <= 1'b0;
         armed     <= 1'b0;
      end else begin
         fire   <= (state_nxt == ST_FIRE);
         load   <= (state_nxt == ST_RELOAD);
         busy   <= (state_nxt != ST_IDLE);
         trig_q <= trigger;
         armed  <= armed | ~trigger;
         if (reload_start) ammo_out <= reload_amt;
         if (fire_start) begin
            fire_rate <= shot_size;
            burst_cnt <= is_burst ? N'(BURST_LEN - 1) : '0;
         end else if (burst_dec) begin
            burst_cnt <= burst_cnt - 1'b1;
         end
         if (err_set) error <= 1'b1;
         else if (!trigger) error <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fire_control_sequencer.sv
// Bench for fire_control_sequencer: cycle model of the shot/reload sequence plus directed scenarios.
module tb_fire_control_sequencer;
   import weapons_pkg::*;

   localparam int N     = 9;
   localparam int COOL  = 4;
   localparam int BURST = 3;
   localparam int LOADC = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         trigger;
   logic [3:0]   mode_sel;
   logic [1:0]   fire_mode;
   logic [N-1:0] shot_size, ammo_level, reload_amt;
   logic         reload_req;
   logic         fire, load, busy, error;
   logic [N-1:0] fire_rate, ammo_out;

   fire_control_sequencer #(
      .N(N), .COOL_CYCLES(COOL), .BURST_LEN(BURST), .LOAD_CYCLES(LOADC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .trigger    (trigger),
      .mode_sel   (mode_sel),
      .fire_mode  (fire_mode),
      .shot_size  (shot_size),
      .ammo_level (ammo_level),
      .reload_req (reload_req),
      .reload_amt (reload_amt),
      .fire       (fire),
      .fire_rate  (fire_rate),
      .load       (load),
      .ammo_out   (ammo_out),
      .busy       (busy),
      .error      (error)
   );

   always #5 clk = ~clk;

   // Model: m_seq marks an active shot sequence, m_pos counts cycles since the last shot
   // (0 = shot cycle); m_reload/m_rl track remaining load cycles; m_burst = shots still owed.
   bit           m_seq = 0, m_reload = 0, m_err = 0, m_trig_q = 0, m_armed = 0;
   int           m_pos = 0, m_rl = 0, m_burst = 0;
   logic [N-1:0] m_rate = '0, m_aout = '0;

   always @(posedge clk or posedge rst) begin : model
      bit           seq, rl_on, err, edg, okv, reqv;
      int           pos, rl, bu;
      logic [N-1:0] rate, aout;
      if (rst) begin
         m_seq <= 0; m_reload <= 0; m_err <= 0; m_trig_q <= 0; m_armed <= 0;
         m_pos <= 0; m_rl <= 0; m_burst <= 0; m_rate <= '0; m_aout <= '0;
      end else begin
         seq = m_seq; rl_on = m_reload; err = m_err; pos = m_pos; rl = m_rl;
         bu = m_burst; rate = m_rate; aout = m_aout;
         edg  = trigger && !m_trig_q && m_armed;
         okv  = (mode_sel == 4'b0010) && (shot_size != 0) && (ammo_level >= shot_size);
         reqv = (fire_mode == 2'b10) ? trigger : edg;
         if (!trigger) err = 0;
         if (rl_on) begin
            rl = rl - 1;
            if (rl == 0) rl_on = 0;
         end else if (seq) begin
            if (pos == COOL) begin
               if (okv && ((fire_mode == 2'b01 && bu > 0) || (fire_mode == 2'b10 && trigger))) begin
                  pos = 0;
                  if (fire_mode == 2'b01) bu = bu - 1;
               end else begin
                  seq = 0;
               end
            end else begin
               pos = pos + 1;
            end
         end else if (reload_req) begin
            rl_on = 1; rl = LOADC; aout = reload_amt;
         end else if (reqv && okv) begin
            seq = 1; pos = 0; rate = shot_size;
            bu = (fire_mode == 2'b01) ? BURST - 1 : 0;
         end else if (reqv) begin
            err = 1;
         end
         m_seq <= seq; m_reload <= rl_on; m_err <= err; m_pos <= pos; m_rl <= rl;
         m_burst <= bu; m_rate <= rate; m_aout <= aout;
         m_trig_q <= trigger;
         m_armed  <= m_armed | ~trigger;
      end
   end

   int errors = 0, checks = 0;
   int fires = 0, loads = 0, cyc = 0;
   bit track = 0;
   int fire_t[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One cycle: compare every output against the model, then let the ammo counter react.
   task automatic tick();
      @(negedge clk);
      cyc++;
      chk("fire",      int'(fire),      int'(m_seq && m_pos == 0));
      chk("load",      int'(load),      int'(m_reload));
      chk("busy",      int'(busy),      int'(m_seq || m_reload));
      chk("error",     int'(error),     int'(m_err));
      chk("fire_rate", int'(fire_rate), int'(m_rate));
      chk("ammo_out",  int'(ammo_out),  int'(m_aout));
      if (fire) begin
         fires++;
         fire_t.push_back(cyc);
      end
      if (load) loads++;
      if (track) begin
         if (m_reload) ammo_level = m_aout;
         else if (m_seq && m_pos == 0)
            ammo_level = (ammo_level >= m_rate) ? ammo_level - m_rate : '0;
      end
   endtask

   task automatic clear_counts();
      fires = 0;
      loads = 0;
      fire_t.delete();
   endtask

   logic [3:0]   rej_mode [3] = '{4'b0100, 4'b0010, 4'b0010};
   logic [N-1:0] rej_shot [3] = '{9'd5, 9'd5, 9'd0};
   logic [N-1:0] rej_ammo [3] = '{9'd500, 9'd2, 9'd500};

   initial begin
      rst = 1; trigger = 0; mode_sel = MODE_ATTACK; fire_mode = FM_SINGLE;
      shot_size = 5; ammo_level = 500; reload_req = 0; reload_amt = 0;
      tick(); tick();
      chk("reset_busy", int'(busy), 0);
      chk("reset_fire_rate", int'(fire_rate), 0);
      rst = 0;
      tick();

      // single shot, trigger held 20 cycles
      clear_counts();
      trigger = 1;
      repeat (20) tick();
      trigger = 0;
      repeat (3) tick();
      chk("single_count", fires, 1);
      chk("single_rate", int'(fire_rate), 5);

      // burst tap
      fire_mode = FM_BURST;
      clear_counts();
      trigger = 1;
      tick();
      trigger = 0;
      repeat (20) tick();
      chk("burst_count", fires, 3);
      if (fire_t.size() == 3) begin
         chk("burst_gap1", fire_t[1] - fire_t[0], 5);
         chk("burst_gap2", fire_t[2] - fire_t[1], 5);
      end
      chk("burst_idle", int'(busy), 0);

      // auto with ammo tracking from 3 rounds
      fire_mode = FM_AUTO; shot_size = 1; ammo_level = 3; track = 1;
      clear_counts();
      trigger = 1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (fires == 3) trigger = 0;
      end
      chk("auto_count", fires, 3);
      chk("auto_ammo", int'(ammo_level), 0);
      chk("auto_error", int'(error), 0);
      track = 0; ammo_level = 500; shot_size = 5; fire_mode = FM_SINGLE;

      // rejected requests
      for (int k = 0; k < 3; k++) begin
         mode_sel = rej_mode[k]; shot_size = rej_shot[k]; ammo_level = rej_ammo[k];
         clear_counts();
         trigger = 1;
         repeat (3) tick();
         chk("reject_no_fire", fires, 0);
         chk("reject_error_set", int'(error), 1);
         trigger = 0;
         tick();
         chk("reject_error_clear", int'(error), 0);
         tick();
      end
      mode_sel = MODE_ATTACK; shot_size = 5; ammo_level = 500;

      // reload and trigger edge in the same cycle
      clear_counts();
      reload_amt = 200; reload_req = 1; trigger = 1;
      tick();
      reload_req = 0;
      repeat (5) tick();
      trigger = 0;
      tick();
      chk("reload_loads", loads, 2);
      chk("reload_no_fire", fires, 0);
      chk("reload_amt", int'(ammo_out), 200);

      // trigger pressed during reload
      clear_counts();
      reload_amt = 100; reload_req = 1;
      tick();
      reload_req = 0; trigger = 1;
      tick();
      trigger = 0;
      repeat (4) tick();
      chk("reload_trig_fire", fires, 0);
      chk("reload_trig_error", int'(error), 0);
      chk("reload_trig_loads", loads, 2);

      // reset in the middle of a burst cool-down, trigger held through release
      fire_mode = FM_BURST;
      trigger = 1;
      tick();
      trigger = 0;
      repeat (3) tick();
      chk("pre_reset_busy", int'(busy), 1);
      clear_counts();
      rst = 1;
      #1;
      chk("rst_fire", int'(fire), 0);
      chk("rst_load", int'(load), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_fire_rate", int'(fire_rate), 0);
      chk("rst_ammo_out", int'(ammo_out), 0);
      trigger = 1;
      tick(); tick();
      rst = 0;
      repeat (4) tick();
      chk("held_through_reset", fires, 0);
      chk("post_reset_idle", int'(busy), 0);
      trigger = 0;
      tick();
      trigger = 1;
      tick();
      chk("repress_after_reset", fires, 1);
      trigger = 0;
      repeat (15) tick();

      // randomized traffic against the model
      track = 1; ammo_level = 50; fire_mode = FM_SINGLE;
      for (int i = 0; i < 4000; i++) begin
         tick();
         if (rst) rst = 0;
         else if ($urandom % 800 == 0) rst = 1;
         if (!m_seq && !m_reload && ($urandom % 8 == 0)) fire_mode = 2'($urandom % 4);
         if ($urandom % 6 == 0) trigger = ~trigger;
         mode_sel  = ($urandom % 20 == 0) ? 4'(1 << ($urandom % 4)) : MODE_ATTACK;
         if ($urandom % 16 == 0) shot_size = N'($urandom % 8);
         reload_req = ($urandom % 40 == 0);
         reload_amt = N'($urandom % 300);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
